// File: rtl/iomem_pwm_leds.sv
// iomem_pwm_leds: 8-channel PWM LED controller, slave on the picosoc iomem bus.
// Duties are double-buffered and swap in at the period wrap, which also raises the interrupt.
module iomem_pwm_leds #(
   parameter logic [7:0] ADDR_HI = 8'h04,
   parameter int         NUM_CH  = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              iomem_valid,
   output logic              iomem_ready,
   input  logic [3:0]        iomem_wstrb,
   input  logic [31:0]       iomem_addr,
   input  logic [31:0]       iomem_wdata,
   output logic [31:0]       iomem_rdata,
   output logic [NUM_CH-1:0] leds,
   output logic              irq
);

   localparam logic [2:0] OFS_CTRL     = 3'd0;
   localparam logic [2:0] OFS_PRESCALE = 3'd1;
   localparam logic [2:0] OFS_DUTY_LO  = 3'd2;
   localparam logic [2:0] OFS_DUTY_HI  = 3'd3;
   localparam logic [2:0] OFS_COUNT    = 3'd4;

   logic                  ready_reg;
   logic [31:0]           rdata_reg;
   logic [31:0]           rdata_next;
   logic                  en_reg;
   logic                  irq_en_reg;
   logic                  irq_pend_reg;
   logic [15:0]           prescale_reg;
   logic [15:0]           pre_cnt_reg;
   logic [7:0]            pwm_cnt_reg;
   logic [NUM_CH*8-1:0]   shadow_reg;
   logic [NUM_CH*8-1:0]   active_reg;
   logic [NUM_CH-1:0]     leds_reg;
   logic [NUM_CH-1:0]     leds_next;
   logic [NUM_CH-1:0]     duty_we;

   logic                  sel;
   logic                  wr_en;
   logic [2:0]            ofs;
   logic                  tick;
   logic                  wrap;
   logic                  w1c_pend;
   logic                  addr_unused;

   // Holding off while ready is high keeps a held valid from being acked twice.
   assign sel      = iomem_valid && !ready_reg && (iomem_addr[31:24] == ADDR_HI);
   assign wr_en    = sel && (iomem_wstrb != 4'b0000);
   assign ofs      = iomem_addr[4:2];
   assign w1c_pend = wr_en && (ofs == OFS_CTRL) && iomem_wstrb[1] && iomem_wdata[8];

   assign addr_unused = ^{iomem_addr[23:5], iomem_addr[1:0]};

   assign tick = en_reg && (pre_cnt_reg == prescale_reg);
   assign wrap = tick && (pwm_cnt_reg == 8'hFF);

   // Per-channel write enables and compare outputs; channel n lives in byte lane n mod 4.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam int         LANE     = gi % 4;
      localparam logic [2:0] OFS_DUTY = (gi < 4) ? OFS_DUTY_LO : OFS_DUTY_HI;

      assign duty_we[gi]   = wr_en && (ofs == OFS_DUTY) && iomem_wstrb[LANE];
      assign leds_next[gi] = en_reg && (pwm_cnt_reg < active_reg[8*gi +: 8]);
   end

   always_comb begin
      rdata_next = 32'd0;
      case (ofs)
         OFS_CTRL:     rdata_next = {23'd0, irq_pend_reg, 6'd0, irq_en_reg, en_reg};
         OFS_PRESCALE: rdata_next = {16'd0, prescale_reg};
         OFS_DUTY_LO:  rdata_next = shadow_reg[31:0];
         OFS_DUTY_HI:  rdata_next = shadow_reg[63:32];
         OFS_COUNT:    rdata_next = {pre_cnt_reg, 8'd0, pwm_cnt_reg};
         default:      rdata_next = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_reg <= 1'b0;
         rdata_reg <= 32'd0;
      end else if (sel) begin
         ready_reg <= 1'b1;
         rdata_reg <= rdata_next;
      end else begin
         ready_reg <= 1'b0;
         rdata_reg <= 32'd0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         en_reg       <= 1'b0;
         irq_en_reg   <= 1'b0;
         irq_pend_reg <= 1'b0;
         prescale_reg <= 16'd0;
      end else begin
         if (wr_en && (ofs == OFS_CTRL) && iomem_wstrb[0]) begin
            en_reg     <= iomem_wdata[0];
            irq_en_reg <= iomem_wdata[1];
         end
         if (wrap) begin
            irq_pend_reg <= 1'b1;
         end else if (w1c_pend) begin
            irq_pend_reg <= 1'b0;
         end
         if (wr_en && (ofs == OFS_PRESCALE)) begin
            if (iomem_wstrb[0]) prescale_reg[7:0]  <= iomem_wdata[7:0];
            if (iomem_wstrb[1]) prescale_reg[15:8] <= iomem_wdata[15:8];
         end
      end
   end

   // A PRESCALE written below pre_cnt simply lets pre_cnt run round through 0xFFFF.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pre_cnt_reg <= 16'd0;
         pwm_cnt_reg <= 8'd0;
      end else if (!en_reg) begin
         pre_cnt_reg <= 16'd0;
         pwm_cnt_reg <= 8'd0;
      end else if (tick) begin
         pre_cnt_reg <= 16'd0;
         pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      end else begin
         pre_cnt_reg <= pre_cnt_reg + 16'd1;
      end
   end

   // Active duty only changes while idle or at the wrap, so a period never glitches.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shadow_reg <= '0;
         active_reg <= '0;
         leds_reg   <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (duty_we[i]) shadow_reg[8*i +: 8] <= iomem_wdata[8*(i%4) +: 8];
         end
         if (!en_reg || wrap) active_reg <= shadow_reg;
         leds_reg <= leds_next;
      end
   end

   assign iomem_ready = ready_reg;
   assign iomem_rdata = rdata_reg;
   assign leds        = leds_reg;
   assign irq         = irq_en_reg & irq_pend_reg;

endmodule
